cam_ctrl: RTL and testbench

CAM_CTRL -- requirements
Module: cam_ctrl

---
 rtl/cam_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_cam_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_ctrl.sv
// Controller sequencing lookup/insert/delete requests onto an external 16-entry CAM.
// Tracks entry occupancy, fills free slots lowest-first and round-robin evicts when full.
module cam_ctrl #(
  parameter int         NB_MEM    = 16,
  parameter logic [7:0] EMPTY_KEY = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_key,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_hit,
  output logic [4:0] rsp_idx,
  output logic       rsp_err,
  output logic       rsp_evict,
  output logic [4:0] count,
  output logic       cam_enable,
  output logic       cam_write,
  output logic [4:0] cam_addr,
  output logic [7:0] cam_data,
  input  logic [4:0] cam_out,
  input  logic       cam_found
);

  localparam logic [4:0] FULL   = 5'(NB_MEM);
  localparam logic [1:0] OP_INS = 2'd1;
  localparam logic [1:0] OP_DEL = 2'd2;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOOK,
    S_CHECK,
    S_WRITE,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          init_cnt_q, init_cnt_d;
  logic [1:0]          op_q, op_d;
  logic [7:0]          key_q, key_d;
  logic [3:0]          cand_q, cand_d;
  logic [3:0]          slot_q, slot_d;
  logic                evict_q, evict_d;
  logic [NB_MEM-1:0]   valid_q, valid_d;
  logic [4:0]          count_q, count_d;
  logic [3:0]          vptr_q, vptr_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic [4:0]          rsp_idx_q, rsp_idx_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_evict_q, rsp_evict_d;
  logic                cam_enable_q, cam_enable_d;
  logic                cam_write_q, cam_write_d;
  logic [4:0]          cam_addr_q, cam_addr_d;
  logic [7:0]          cam_data_q, cam_data_d;

  logic [3:0] free_idx;
  logic       hit;
  logic       cam_out_unused;

  assign cam_out_unused = cam_out[4];

  // Descending scan so the lowest-numbered free entry wins.
  always_comb begin
    free_idx = 4'd0;
    for (int i = NB_MEM - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = 4'(i);
    end
  end

  // A stale CAM match on an invalid entry must never count as a hit.
  assign hit = cam_found & valid_q[cand_q];

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    op_d         = op_q;
    key_d        = key_q;
    cand_d       = cand_q;
    slot_d       = slot_q;
    evict_d      = evict_q;
    valid_d      = valid_q;
    count_d      = count_q;
    vptr_d       = vptr_q;
    rsp_hit_d    = rsp_hit_q;
    rsp_idx_d    = rsp_idx_q;
    rsp_err_d    = rsp_err_q;
    rsp_evict_d  = rsp_evict_q;
    cam_enable_d = 1'b0;
    cam_write_d  = 1'b0;
    cam_addr_d   = cam_addr_q;
    cam_data_d   = cam_data_q;

    // CAM strobes are registered, so they are set up for the state being entered.
    unique case (state_q)
      S_INIT: begin
        if (init_cnt_q == FULL) begin
          state_d = S_IDLE;
        end else begin
          cam_write_d = 1'b1;
          cam_addr_d  = init_cnt_q;
          cam_data_d  = EMPTY_KEY;
          init_cnt_d  = init_cnt_q + 5'd1;
        end
      end

      S_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          key_d = req_key;
          if (req_key == EMPTY_KEY) begin
            state_d     = S_RESP;
            rsp_err_d   = 1'b1;
            rsp_hit_d   = 1'b0;
            rsp_idx_d   = 5'd0;
            rsp_evict_d = 1'b0;
          end else begin
            state_d      = S_LOOK;
            cam_enable_d = 1'b1;
            cam_data_d   = req_key;
          end
        end
      end

      S_LOOK: begin
        cand_d     = cam_out[3:0];
        cam_data_d = key_q;
        state_d    = S_CHECK;
      end

      S_CHECK: begin
        state_d     = S_RESP;
        rsp_err_d   = 1'b0;
        rsp_evict_d = 1'b0;
        rsp_hit_d   = hit;
        rsp_idx_d   = hit ? {1'b0, cand_q} : 5'd0;
        if (op_q == OP_INS && !hit) begin
          state_d     = S_WRITE;
          evict_d     = (count_q == FULL);
          slot_d      = (count_q == FULL) ? vptr_q : free_idx;
          if (count_q == FULL) vptr_d = vptr_q + 4'd1;
          cam_write_d = 1'b1;
          cam_addr_d  = {1'b0, slot_d};
          cam_data_d  = key_q;
        end else if (op_q == OP_DEL && hit) begin
          state_d     = S_WRITE;
          evict_d     = 1'b0;
          slot_d      = cand_q;
          cam_write_d = 1'b1;
          cam_addr_d  = {1'b0, cand_q};
          cam_data_d  = EMPTY_KEY;
        end
      end

      S_WRITE: begin
        state_d = S_RESP;
        if (op_q == OP_DEL) begin
          valid_d[slot_q] = 1'b0;
          count_d         = count_q - 5'd1;
        end else begin
          valid_d[slot_q] = 1'b1;
          if (!evict_q) count_d = count_q + 5'd1;
          rsp_hit_d   = 1'b0;
          rsp_idx_d   = {1'b0, slot_q};
          rsp_evict_d = evict_q;
        end
      end

      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      init_cnt_q   <= 5'd0;
      op_q         <= 2'd0;
      key_q        <= 8'd0;
      cand_q       <= 4'd0;
      slot_q       <= 4'd0;
      evict_q      <= 1'b0;
      valid_q      <= '0;
      count_q      <= 5'd0;
      vptr_q       <= 4'd0;
      rsp_hit_q    <= 1'b0;
      rsp_idx_q    <= 5'd0;
      rsp_err_q    <= 1'b0;
      rsp_evict_q  <= 1'b0;
      cam_enable_q <= 1'b0;
      cam_write_q  <= 1'b0;
      cam_addr_q   <= 5'd0;
      cam_data_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      op_q         <= op_d;
      key_q        <= key_d;
      cand_q       <= cand_d;
      slot_q       <= slot_d;
      evict_q      <= evict_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      vptr_q       <= vptr_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_idx_q    <= rsp_idx_d;
      rsp_err_q    <= rsp_err_d;
      rsp_evict_q  <= rsp_evict_d;
      cam_enable_q <= cam_enable_d;
      cam_write_q  <= cam_write_d;
      cam_addr_q   <= cam_addr_d;
      cam_data_q   <= cam_data_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_hit    = rsp_hit_q;
  assign rsp_idx    = rsp_idx_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_evict  = rsp_evict_q;
  assign count      = count_q;
  assign cam_enable = cam_enable_q;
  assign cam_write  = cam_write_q;
  assign cam_addr   = cam_addr_q;
  assign cam_data   = cam_data_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Scoreboard bench for cam_ctrl: directed scenarios then random traffic against
// an associative-table reference model, with a behavioural CAM attached.
module tb_cam_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_key;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_hit;
  logic [4:0] rsp_idx;
  logic       rsp_err;
  logic       rsp_evict;
  logic [4:0] count;
  logic       cam_enable;
  logic       cam_write;
  logic [4:0] cam_addr;
  logic [7:0] cam_data;
  logic [4:0] cam_out;
  logic       cam_found;

  cam_ctrl #(.NB_MEM(16), .EMPTY_KEY(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx),
    .rsp_err(rsp_err), .rsp_evict(rsp_evict), .count(count),
    .cam_enable(cam_enable), .cam_write(cam_write), .cam_addr(cam_addr), .cam_data(cam_data),
    .cam_out(cam_out), .cam_found(cam_found)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural CAM: combinational match index, registered found flag.
  logic [7:0] cam_mem [16];
  logic       cam_any;
  always_comb begin
    cam_out = 5'd0;
    cam_any = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (cam_mem[i] == cam_data) begin
        cam_out = 5'(i);
        cam_any = 1'b1;
      end
    end
  end
  always @(posedge clk) begin
    if (cam_write) cam_mem[cam_addr[3:0]] <= cam_data;
    if (cam_enable && !cam_write) cam_found <= cam_any;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit       hit;
    bit [4:0] idx;
    bit       err;
    bit       evict;
    bit [4:0] cnt;
    int       lat;
    int       nwr;
    bit [4:0] waddr;
    bit [7:0] wdata;
    int       t_acc;
    bit [1:0] op;
    bit [7:0] key;
  } exp_t;

  exp_t        exp_q[$];
  logic [12:0] wr_log[$];
  bit          in_resp = 1'b0;

  // Reference model: a table of keys with occupancy flags.
  bit [7:0] m_keys [16];
  bit       m_vld  [16];
  int       m_cnt;
  int       m_vptr;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_keys[i] = 8'hFF;
      m_vld[i]  = 1'b0;
    end
    m_cnt  = 0;
    m_vptr = 0;
  endtask

  task automatic model_op(input bit [1:0] op, input bit [7:0] key, output exp_t e);
    int found;
    int slot;
    e = '{default: 0};
    e.op  = op;
    e.key = key;
    if (key == 8'hFF) begin
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      found = -1;
      for (int i = 0; i < 16; i++)
        if (m_vld[i] && m_keys[i] == key) found = i;
      e.lat = 3;
      if (op == 2'd1) begin
        if (found >= 0) begin
          e.hit = 1'b1;
          e.idx = 5'(found);
        end else begin
          if (m_cnt < 16) begin
            slot = -1;
            for (int i = 15; i >= 0; i--) if (!m_vld[i]) slot = i;
            m_cnt++;
          end else begin
            slot    = m_vptr;
            e.evict = 1'b1;
            m_vptr  = (m_vptr + 1) % 16;
          end
          m_keys[slot] = key;
          m_vld[slot]  = 1'b1;
          e.idx   = 5'(slot);
          e.lat   = 4;
          e.nwr   = 1;
          e.waddr = 5'(slot);
          e.wdata = key;
        end
      end else if (op == 2'd2) begin
        if (found >= 0) begin
          m_vld[found] = 1'b0;
          m_cnt--;
          e.hit   = 1'b1;
          e.idx   = 5'(found);
          e.lat   = 4;
          e.nwr   = 1;
          e.waddr = 5'(found);
          e.wdata = 8'hFF;
        end
      end else if (found >= 0) begin
        e.hit = 1'b1;
        e.idx = 5'(found);
      end
    end
    e.cnt = 5'(m_cnt);
  endtask

  // CAM strobe monitor and write log.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cam_write || cam_enable) check("cam_strobe_exclusive", int'(cam_write && cam_enable), 0);
        if (cam_write) wr_log.push_back({cam_addr, cam_data});
      end
    end
  end

  // Response monitor: owns rsp_ready, pops the scoreboard on each new response.
  initial begin
    exp_t     e;
    int       hold_left;
    bit [7:0] held;
    rsp_ready = 1'b0;
    hold_left = 0;
    held      = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_resp   = 1'b0;
        rsp_ready = 1'b0;
      end else begin
        if (in_resp && rsp_ready) begin
          in_resp   = 1'b0;
          rsp_ready = 1'b0;
        end
        if (in_resp && !rsp_valid) begin
          check("rsp_dropped_before_ready", 0, 1);
          in_resp = 1'b0;
        end
        if (rsp_valid) begin
          check("req_ready_low_in_resp", int'(req_ready), 0);
          if (!in_resp) begin
            in_resp = 1'b1;
            if (exp_q.size() == 0) begin
              check("unexpected_response", 1, 0);
            end else begin
              e = exp_q.pop_front();
              $display("rsp op=%0d key=%02h hit=%0d idx=%0d err=%0d evict=%0d count=%0d lat=%0d",
                       e.op, e.key, rsp_hit, rsp_idx, rsp_err, rsp_evict, count, cyc - e.t_acc);
              check("rsp_latency", cyc - e.t_acc, e.lat);
              check("rsp_err",   int'(rsp_err),   int'(e.err));
              check("rsp_hit",   int'(rsp_hit),   int'(e.hit));
              check("rsp_idx",   int'(rsp_idx),   int'(e.idx));
              check("rsp_evict", int'(rsp_evict), int'(e.evict));
              check("count",     int'(count),     int'(e.cnt));
              check("cam_write_count", wr_log.size(), e.nwr);
              if (e.nwr > 0 && wr_log.size() > 0) begin
                check("cam_write_addr", int'(wr_log[$][12:8]), int'(e.waddr));
                check("cam_write_data", int'(wr_log[$][7:0]),  int'(e.wdata));
              end
            end
            wr_log.delete();
            held      = {rsp_hit, rsp_idx, rsp_err, rsp_evict};
            hold_left = $urandom_range(0, 6);
          end else begin
            check("rsp_stable", int'({rsp_hit, rsp_idx, rsp_err, rsp_evict}), int'(held));
          end
          if (hold_left > 0) hold_left--;
          rsp_ready = (hold_left == 0);
        end
      end
    end
  end

  task automatic do_req(input bit [1:0] op, input bit [7:0] key);
    exp_t e;
    int   k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 0, 1);
      return;
    end
    model_op(op, key, e);
    e.t_acc = cyc;
    exp_q.push_back(e);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    int k;
    rst_n = 1'b0;
    exp_q.delete();
    model_clear();
    repeat (3) begin
      @(negedge clk);
      check("rst_quiet", int'({cam_write, cam_enable, rsp_valid, req_ready, rsp_hit, rsp_err, rsp_evict}), 0);
      check("rst_count", int'(count), 0);
      check("rst_cam_bus", int'({cam_addr, cam_data, rsp_idx}), 0);
    end
    wr_log.delete();
    rst_n = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req_ready && k < 40);
    $display("reset released: ready after %0d cycles, %0d init writes", k, wr_log.size());
    check("ready_after_release_cycles", k, 17);
    check("count_after_init", int'(count), 0);
    check("init_write_count", wr_log.size(), 16);
    foreach (wr_log[i]) begin
      check("init_write_addr", int'(wr_log[i][12:8]), i);
      check("init_write_data", int'(wr_log[i][7:0]), 255);
    end
    wr_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit [1:0] op;
    bit [7:0] key;
    int r;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_key   = 8'd0;
    repeat (2) @(negedge clk);
    do_reset();

    // Basic insert / lookup / duplicate insert.
    do_req(2'd1, 8'h3C);
    do_req(2'd0, 8'h3C);
    do_req(2'd1, 8'h3C);
    // Fill to 16, then evict round-robin.
    for (int i = 0; i < 15; i++) do_req(2'd1, 8'(8'h40 + i));
    do_req(2'd1, 8'hA5);
    do_req(2'd1, 8'h77);
    // Delete entry 5, refill it, error and miss paths.
    do_req(2'd2, 8'h44);
    do_req(2'd1, 8'h88);
    do_req(2'd0, 8'hFF);
    do_req(2'd2, 8'h99);
    do_req(2'd3, 8'h3C);
    do_req(2'd3, 8'h41);

    // Reset pulsed while a write is in flight: no response, INIT reruns.
    do_req(2'd1, 8'hC3);
    k = 0;
    while (!cam_write && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("abort_reached_write", int'(cam_write), 1);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 7);
      op = (r < 4) ? 2'd1 : (r < 6) ? 2'd2 : (r == 6) ? 2'd0 : 2'd3;
      key = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 23));
      do_req(op, key);
    end

    k = 0;
    while ((exp_q.size() != 0 || in_resp) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_scoreboard", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
